// File: rtl/iq_sched_pkg.sv
// Shared constants for the IQ stream scheduler: frame packing, widths and defaults.
// IQ_SEQ_TAG_EN widens each FIFO entry by a 16-bit sequence tag.
package iq_sched_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int FRAME_W   = 128;
  localparam int TAG_W     = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_LVL_W = 4;

  // Frame packing, MSB first: {RX1_Q, RX1_I, RX2_Q, RX2_I}
  localparam int RX1_Q_LSB = 96;
  localparam int RX1_I_LSB = 64;
  localparam int RX2_Q_LSB = 32;
  localparam int RX2_I_LSB = 0;

`ifdef IQ_SEQ_TAG_EN
  localparam int OUT_W = TAG_W + FRAME_W;
`else
  localparam int OUT_W = FRAME_W;
`endif

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [SAMPLE_W-1:0] rx1_i,
                                                    input logic [SAMPLE_W-1:0] rx1_q,
                                                    input logic [SAMPLE_W-1:0] rx2_i,
                                                    input logic [SAMPLE_W-1:0] rx2_q);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[RX1_Q_LSB +: SAMPLE_W] = rx1_q;
    f[RX1_I_LSB +: SAMPLE_W] = rx1_i;
    f[RX2_Q_LSB +: SAMPLE_W] = rx2_q;
    f[RX2_I_LSB +: SAMPLE_W] = rx2_i;
    return f;
  endfunction

endpackage

// File: rtl/iq_stream_scheduler_if.sv
// Bus-interface side of the IQ stream scheduler (RX IQ read path and status).
// Entry width follows iq_sched_pkg::OUT_W, which grows under IQ_SEQ_TAG_EN.
interface iq_stream_scheduler_if #(
  parameter int LVL_W = iq_sched_pkg::DEF_LVL_W
);

  // pop_req: one-cycle pulse that consumes the head shown on frame_out while
  // frame_valid is high; the next head is on frame_out the following cycle.
  // A pop_req while frame_valid is low is dropped and raises underflow.
  logic                          pop_req;
  logic                          flags_clr;
  logic [iq_sched_pkg::OUT_W-1:0] frame_out;
  logic                          frame_valid;
  logic [LVL_W-1:0]              fifo_level;
  logic                          IQ_IRQ;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output pop_req, flags_clr,
    input  frame_out, frame_valid, fifo_level, IQ_IRQ, overflow, underflow
  );

  modport slave (
    input  pop_req, flags_clr,
    output frame_out, frame_valid, fifo_level, IQ_IRQ, overflow, underflow
  );

endinterface

// File: rtl/iq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for an asynchronous strobe.
module iq_sync_edge (
  input  logic clk_in,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  // sync_q[1] is the synchronized level, sync_q[2] its previous value
  logic [2:0] sync_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], async_in};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/iq_stream_scheduler.sv
// Buffers DDC IQ frames in a show-ahead FIFO for the STM32 RX IQ read path.
// Optional IQ_SEQ_TAG_EN prepends a 16-bit push sequence tag to every entry.
module iq_stream_scheduler
  import iq_sched_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IRQ_THRESH = 1,
  parameter int LVL_W      = DEF_LVL_W
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       rx_enable,
  input  logic signed [SAMPLE_W-1:0] RX1_I,
  input  logic signed [SAMPLE_W-1:0] RX1_Q,
  input  logic signed [SAMPLE_W-1:0] RX2_I,
  input  logic signed [SAMPLE_W-1:0] RX2_Q,
  input  logic                       IQ_valid,
  iq_stream_scheduler_if.slave       bus
);

  localparam int AW = LVL_W - 1;

  logic               rise;
  logic               stage_valid;
  logic [FRAME_W-1:0] stage_frame;
  logic [OUT_W-1:0]   stage_entry;
  logic [OUT_W-1:0]   mem [DEPTH];
  logic [LVL_W-1:0]   wr_ptr, rd_ptr, level_q;
  logic [LVL_W-1:0]   wr_n, rd_n, level_n;
  logic [OUT_W-1:0]   frame_q, head_n;
  logic               irq_q, ovf_q, unf_q;
  logic               empty, full;
  logic               push_req, do_push, do_pop, ovf_evt, unf_evt;

  iq_sync_edge u_sync (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .async_in (IQ_valid),
    .rise     (rise)
  );

  // Edges seen while disabled are never staged, so re-enabling needs a fresh strobe
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_frame <= '0;
    end else if (!rx_enable) begin
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= rise;
      if (rise) stage_frame <= pack_frame(RX1_I, RX1_Q, RX2_I, RX2_Q);
    end
  end

`ifdef IQ_SEQ_TAG_EN
  // Counts every push attempt, dropped ones included, so gaps are visible
  logic [TAG_W-1:0] tag_cnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)      tag_cnt <= '0;
    else if (push_req) tag_cnt <= tag_cnt + 1'b1;
  end

  assign stage_entry = {tag_cnt, stage_frame};
`else
  assign stage_entry = stage_frame;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    push_req = stage_valid && rx_enable;
    do_pop   = bus.pop_req && rx_enable && !empty;
    do_push  = push_req && (!full || do_pop);
    ovf_evt  = push_req && full && !do_pop;
    unf_evt  = bus.pop_req && rx_enable && empty;
    wr_n     = wr_ptr + LVL_W'(do_push);
    rd_n     = rd_ptr + LVL_W'(do_pop);
    level_n  = wr_n - rd_n;
    // Bypass when the entry being written becomes the new head
    head_n   = (do_push && (wr_ptr == rd_n)) ? stage_entry : mem[rd_n[AW-1:0]];
    if (level_n == '0) head_n = '0;
    if (!rx_enable) begin
      wr_n    = '0;
      rd_n    = '0;
      level_n = '0;
      head_n  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= stage_entry;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      frame_q <= '0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_n;
      rd_ptr  <= rd_n;
      level_q <= level_n;
      frame_q <= head_n;
      irq_q   <= rx_enable && (level_q >= LVL_W'(IRQ_THRESH));
      if (ovf_evt)            ovf_q <= 1'b1;
      else if (bus.flags_clr) ovf_q <= 1'b0;
      if (unf_evt)            unf_q <= 1'b1;
      else if (bus.flags_clr) unf_q <= 1'b0;
    end
  end

  assign bus.frame_out   = frame_q;
  assign bus.frame_valid = (level_q != '0);
  assign bus.fifo_level  = level_q;
  assign bus.IQ_IRQ      = irq_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_iq_stream_scheduler.sv
// Self-checking bench for iq_stream_scheduler; builds with or without IQ_SEQ_TAG_EN.
module tb_iq_stream_scheduler;
  import iq_sched_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 160;

  logic clk_in = 1'b0;
  logic reset_n;
  logic rx_enable;
  logic IQ_valid;
  logic signed [31:0] RX1_I, RX1_Q, RX2_I, RX2_Q;

  iq_stream_scheduler_if bus_if ();

  iq_stream_scheduler dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .rx_enable (rx_enable),
    .RX1_I     (RX1_I),
    .RX1_Q     (RX1_Q),
    .RX2_I     (RX2_I),
    .RX2_Q     (RX2_Q),
    .IQ_valid  (IQ_valid),
    .bus       (bus_if)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  logic [15:0]      tag_model;
  logic             exp_ovf;
  int               chk_cnt = 0;
  int               err_cnt = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] make_entry(input logic [31:0] i1, input logic [31:0] q1,
                                                  input logic [31:0] i2, input logic [31:0] q2);
    logic [127:0] f;
    f = {q1, i1, q2, i2};
`ifdef IQ_SEQ_TAG_EN
    return {tag_model, f};
`else
    return f;
`endif
  endfunction

  // driver: one IQ_valid pulse held 4 cycles, then 2 low; push lands before it returns
  task automatic pulse_iq(input logic [31:0] i1, input logic [31:0] q1,
                          input logic [31:0] i2, input logic [31:0] q2);
    logic [OUT_W-1:0] e;
    RX1_I = i1; RX1_Q = q1; RX2_I = i2; RX2_Q = q2;
    IQ_valid = 1'b1;
    e = make_entry(i1, q1, i2, q2);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
    tag_model++;
    repeat (4) @(negedge clk_in);
    IQ_valid = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic pulse_pop();
    bus_if.pop_req = 1'b1;
    @(negedge clk_in);
    bus_if.pop_req = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_empty_model"}, CW'(bus_if.frame_valid), CW'(0));
    end else begin
      check(tag, CW'(bus_if.frame_out), CW'(exp_q.pop_front()));
      pulse_pop();
    end
  endtask

  task automatic pulse_clr();
    bus_if.flags_clr = 1'b1;
    @(negedge clk_in);
    bus_if.flags_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame"}, CW'(bus_if.frame_out), CW'(0));
    check({tag, "_valid"}, CW'(bus_if.frame_valid), CW'(0));
    check({tag, "_level"}, CW'(bus_if.fifo_level), CW'(0));
    check({tag, "_irq"},   CW'(bus_if.IQ_IRQ), CW'(0));
    check({tag, "_ovf"},   CW'(bus_if.overflow), CW'(0));
    check({tag, "_unf"},   CW'(bus_if.underflow), CW'(0));
  endtask

  initial begin
    reset_n = 1'b0; rx_enable = 1'b0; IQ_valid = 1'b0;
    RX1_I = '0; RX1_Q = '0; RX2_I = '0; RX2_Q = '0;
    bus_if.pop_req = 1'b0; bus_if.flags_clr = 1'b0;
    tag_model = '0; exp_ovf = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    reset_n = 1'b1; rx_enable = 1'b1;
    repeat (2) @(negedge clk_in);

    // three frames, no pops
    pulse_iq(32'h11, 32'hA1, 32'hB1, 32'hC1);
    pulse_iq(32'h22, 32'hA2, 32'hB2, 32'hC2);
    pulse_iq(32'h33, 32'hA3, 32'hB3, 32'hC3);
    check("lvl3", CW'(bus_if.fifo_level), CW'(exp_q.size()));
    check("irq3", CW'(bus_if.IQ_IRQ), CW'(1));
    check("valid3", CW'(bus_if.frame_valid), CW'(1));
    for (int i = 0; i < 3; i++) pop_check("pop3");
    check("lvl0", CW'(bus_if.fifo_level), CW'(0));
    @(negedge clk_in);
    check("irq0", CW'(bus_if.IQ_IRQ), CW'(0));

    // nine pushes into a depth-8 FIFO
    for (int i = 1; i <= 9; i++)
      pulse_iq(32'h100 + i, 32'h200 + i, 32'h300 + i, 32'h400 + i);
    check("lvl_full", CW'(bus_if.fifo_level), CW'(DEPTH));
    check("ovf_set", CW'(bus_if.overflow), CW'(exp_ovf));
    for (int i = 0; i < DEPTH; i++) pop_check("pop_full");
    check("lvl_drained", CW'(bus_if.fifo_level), CW'(0));
    pulse_clr();
    exp_ovf = 1'b0;
    check("ovf_clr", CW'(bus_if.overflow), CW'(0));

    // push coinciding with a pop while full
    for (int i = 1; i <= DEPTH; i++)
      pulse_iq(32'h500 + i, 32'h600 + i, 32'h700 + i, 32'h800 + i);
    begin
      logic [OUT_W-1:0] e;
      RX1_I = 32'hCAFE0001; RX1_Q = 32'hCAFE0002; RX2_I = 32'hCAFE0003; RX2_Q = 32'hCAFE0004;
      IQ_valid = 1'b1;
      e = make_entry(RX1_I, RX1_Q, RX2_I, RX2_Q);
      tag_model++;
      repeat (3) @(negedge clk_in);
      check("cp_head", CW'(bus_if.frame_out), CW'(exp_q.pop_front()));
      exp_q.push_back(e);
      pulse_pop();
      check("cp_lvl", CW'(bus_if.fifo_level), CW'(DEPTH));
      check("cp_ovf", CW'(bus_if.overflow), CW'(0));
      @(negedge clk_in);
      IQ_valid = 1'b0;
      repeat (2) @(negedge clk_in);
    end
    for (int i = 0; i < DEPTH; i++) pop_check("cp_drain");

    // underflow and flag precedence
    pulse_pop();
    check("unf_set", CW'(bus_if.underflow), CW'(1));
    check("unf_lvl", CW'(bus_if.fifo_level), CW'(0));
    pulse_clr();
    check("unf_clr", CW'(bus_if.underflow), CW'(0));
    bus_if.flags_clr = 1'b1;
    pulse_pop();
    bus_if.flags_clr = 1'b0;
    check("unf_wins", CW'(bus_if.underflow), CW'(1));

    // rx_enable dropped for one cycle with five queued
    for (int i = 1; i <= 5; i++)
      pulse_iq(32'h900 + i, 32'hA00 + i, 32'hB00 + i, 32'hC00 + i);
    check("en_lvl5", CW'(bus_if.fifo_level), CW'(5));
    rx_enable = 1'b0;
    @(negedge clk_in);
    rx_enable = 1'b1;
    exp_q.delete();
    check("dis_lvl", CW'(bus_if.fifo_level), CW'(0));
    check("dis_valid", CW'(bus_if.frame_valid), CW'(0));
    check("dis_irq", CW'(bus_if.IQ_IRQ), CW'(0));
    check("dis_unf_kept", CW'(bus_if.underflow), CW'(1));
    pulse_iq(32'hD00D0001, 32'hD00D0002, 32'hD00D0003, 32'hD00D0004);
    check("re_lvl", CW'(bus_if.fifo_level), CW'(1));
    pop_check("re_head");
    pulse_clr();

    // random frames
    for (int i = 0; i < 4; i++)
      pulse_iq($urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0),
               $urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0));
    for (int i = 0; i < 4; i++) pop_check("rnd");

    // ten pushes (two dropped), eight pops, then one more push
    for (int i = 0; i < 10; i++)
      pulse_iq(32'hE00 + i, 32'hE10 + i, 32'hE20 + i, 32'hE30 + i);
    check("tag_ovf", CW'(bus_if.overflow), CW'(exp_ovf));
    for (int i = 0; i < DEPTH; i++) pop_check("tag_pop");
    pulse_iq(32'hF1, 32'hF2, 32'hF3, 32'hF4);
    pop_check("tag_next");

    // asynchronous reset in the middle of a capture
    pulse_iq(32'h77, 32'h78, 32'h79, 32'h7A);
    IQ_valid = 1'b1;
    repeat (2) @(negedge clk_in);
    #2;
    reset_n = 1'b0;
    IQ_valid = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete(); tag_model = '0; exp_ovf = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (6) @(negedge clk_in);
    check("post_rst_lvl", CW'(bus_if.fifo_level), CW'(0));
    check("post_rst_valid", CW'(bus_if.frame_valid), CW'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
